det_1011: RTL and testbench
===========================

DET_1011 -- requirements
Module: det_1011

Interface
REQ-001 SHALL provide parameter PAT_LEN, default 4, meaning the pattern length in bits (legal range 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b1011, meaning the target sequence; the MSB is the first bit received.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL provide port sin, input, 1 bit: serial data, one bit sampled per rising clk edge.
REQ-006 SHALL provide port y, output, 1 bit: registered detect pulse.
REQ-007 SHALL keep the port order clk-independent positional as (sin, clk, reset, y).

Function
REQ-008 SHALL track the match progress as a state k = number of pattern bits currently matched, with 0 <= k <= PAT_LEN-1, encoded in ceil(log2(PAT_LEN)) bits.
REQ-009 SHALL, on each rising edge with the next pattern bit equal to sin, advance k by 1 when k < PAT_LEN-1.
REQ-010 SHALL, on a mismatch, set k to the length of the longest proper pattern prefix that is a suffix of the received bits (failure function, computed at elaboration from PATTERN); for 1011: k0 --0--> 0, k1 --1--> 1, k2 --0--> 0, k3 --0--> 2.
REQ-011 SHALL treat a complete match as k == PAT_LEN-1 with sin equal to the final pattern bit.
REQ-012 SHALL register y high on the edge that samples the final matching bit, so y is high for exactly one clock cycle following that edge; otherwise y SHALL be low.
REQ-013 SHALL, in non-overlapping mode, return k to 0 on a complete match, so no bit contributes to two detections.
REQ-014 SHALL assert y for consecutive cycles only if the pattern completes on consecutive edges, which is impossible for PAT_LEN >= 2 in non-overlapping mode.
REQ-015 SHALL contain no combinational path from sin to y.

Reset
REQ-016 SHALL, while reset is high, immediately force k to 0 and y to 0, independently of clk.
REQ-017 SHALL, with reset asserted in the middle of a partial match, discard that progress; detection restarts from the first edge after release.
REQ-018 SHALL sample sin normally on the first rising edge after reset deasserts, with no dead cycle.

Configuration
REQ-019 SHALL support a preprocessor macro DET_OVERLAP_EN; when it is defined, a complete match SHALL set k to the failure value of the full pattern (1 for 1011), so overlapping occurrences are detected.
REQ-020 SHALL, when DET_OVERLAP_EN is undefined (the default), behave in non-overlapping mode per REQ-013.

Verification
REQ-021 Reset check: hold reset=1 with sin toggling for 3 edges -> y=0 and k=0 throughout; assert reset between edges -> y falls immediately.
REQ-022 Basic detection: after reset, sin = 0,1,0,1,1,0,0,1,1,1,1 on successive edges -> y=1 for exactly one cycle after the 5th edge (bits 1,0,1,1), and 0 elsewhere.
REQ-023 Non-overlap: sin = 1,0,1,1,0,1,1 -> a single y pulse after the 4th bit; with DET_OVERLAP_EN defined -> pulses after the 4th and 7th bits.
REQ-024 Mismatch fallback: sin = 1,0,1,0,1,1 -> y pulses after the 6th bit (the k3-->2 fallback is exercised).
REQ-025 Reset mid-match: sin = 1,0,1, then pulse reset, then 1 -> no pulse; then 0,1,1 -> pulse.
REQ-026 Parameter check: PAT_LEN=3, PATTERN=3'b110, sin = 1,1,1,0 -> one pulse after the 4th bit.

Source files
------------

// File: rtl/det_1011.sv
// Serial pattern detector: KMP-style match automaton with a registered one-cycle detect pulse.
// Optional macro DET_OVERLAP_EN: a complete match falls back to the pattern's failure value instead of 0.
module det_1011 #(
    parameter int unsigned           PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0]    PATTERN = 4'b1011
) (
    input  logic sin,
    input  logic clk,
    input  logic reset,
    output logic y
);

    localparam int unsigned KW     = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int unsigned NSTATE = 2 ** KW;
    localparam logic        LAST   = PATTERN[0];

`ifdef DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    // Pattern bit i, counted from the first bit received (the MSB of PATTERN).
    function automatic logic pat_bit(input int unsigned i);
        logic [15:0] t;
        t = 16'(PATTERN) >> (PAT_LEN - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b),
    // capped below PAT_LEN so a full match yields the failure value of the whole pattern.
    function automatic int unsigned step(input int unsigned k, input logic b);
        int unsigned maxj;
        int unsigned res;
        int unsigned pos;
        logic        ok;
        logic        sb;
        maxj = (k >= PAT_LEN - 1) ? PAT_LEN - 1 : k + 1;
        res  = 0;
        for (int unsigned j = 1; j <= maxj; j++) begin
            ok = 1'b1;
            for (int unsigned m = 0; m < j; m++) begin
                pos = k + 1 - j + m;
                sb  = (pos == k) ? b : pat_bit(pos);
                if (sb != pat_bit(m)) ok = 1'b0;
            end
            if (ok) res = j;
        end
        return res;
    endfunction

    logic [KW-1:0] nxt0 [NSTATE];
    logic [KW-1:0] nxt1 [NSTATE];

    // Transition table, fixed at elaboration; unreachable codes park in state 0.
    for (genvar g = 0; g < NSTATE; g++) begin : g_tbl
        if (g < PAT_LEN) begin : g_live
            assign nxt0[g] = KW'(step(g, 1'b0));
            assign nxt1[g] = KW'(step(g, 1'b1));
        end else begin : g_pad
            assign nxt0[g] = '0;
            assign nxt1[g] = '0;
        end
    end

    logic [KW-1:0] k;
    logic [KW-1:0] k_nxt;
    logic          hit_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k <= '0;
            y <= 1'b0;
        end else begin
            k <= k_nxt;
            y <= hit_c;
        end
    end

    always_comb begin
        k_nxt = k;
        hit_c = 1'b0;
        k_nxt = sin ? nxt1[k] : nxt0[k];
        if ((k == KW'(PAT_LEN - 1)) && (sin == LAST)) begin
            hit_c = 1'b1;
            if (!OVERLAP) k_nxt = '0;
        end
    end

endmodule

// File: tb/tb_det_1011.sv
// Scoreboard bench for det_1011: driver queues expected y per edge, monitor checks after each edge.
module tb_det_1011;

`ifdef DET_OVERLAP_EN
    localparam logic OVL = 1'b1;
`else
    localparam logic OVL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic sin;
    logic y;
    logic y2;

    int n_chk  = 0;
    int n_fail = 0;
    logic q1 [$];
    logic q2 [$];
    int   idx1 = 0;
    int   idx2 = 0;

    always #5 clk = ~clk;

    det_1011 u_dut (
        .sin   (sin),
        .clk   (clk),
        .reset (reset),
        .y     (y)
    );

    det_1011 #(.PAT_LEN(3), .PATTERN(3'b110)) u_dut3 (
        .sin   (sin),
        .clk   (clk),
        .reset (reset),
        .y     (y2)
    );

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %b, expected %b at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Monitor: y is checked one time unit after every edge that has an expectation queued.
    always begin
        @(posedge clk);
        #1;
        if (q1.size() > 0) begin
            check("y", idx1, y, q1.pop_front());
            idx1++;
        end
        if (q2.size() > 0) begin
            check("y_len3", idx2, y2, q2.pop_front());
            idx2++;
        end
    end

    // Drive one bit before the next edge and queue the expected y after that edge.
    task automatic send(input logic b, input logic e, input bit sel);
        sin = b;
        if (sel) q2.push_back(e);
        else     q1.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_vec(input logic [15:0] bits, input logic [15:0] exps,
                           input int n, input bit sel);
        logic [15:0] tb;
        logic [15:0] te;
        for (int i = 0; i < n; i++) begin
            tb = bits >> (n - 1 - i);
            te = exps >> (n - 1 - i);
            send(tb[0], te[0], sel);
        end
    endtask

    // Reset pulse between edges; y must drop without waiting for a clock.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("rst_async_y", 0, y, 1'b0);
        check("rst_async_y_len3", 0, y2, 1'b0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        sin   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_y", 0, y, 1'b0);
        check("reset_k", 0, 1'(u_dut.k == '0), 1'b1);

        // Reset held with sin toggling.
        for (int i = 0; i < 3; i++) begin
            send(1'(i % 2 == 0), 1'b0, 1'b0);
            check("hold_k", i, 1'(u_dut.k == '0), 1'b1);
        end
        reset = 1'b0;

        // Basic detection, first edge after release is live.
        run_vec(16'b01011001111, 16'b00001000000, 11, 1'b0);

        // Asynchronous fall of a high y.
        pulse_reset();
        run_vec(16'b1011, 16'b0001, 4, 1'b0);
        check("y_before_rst", 0, y, 1'b1);
        pulse_reset();

        // Overlap behaviour depends on the build.
        run_vec(16'b1011011, {9'b0, 6'b000100, OVL}, 7, 1'b0);

        // k3 --0--> 2 fallback.
        pulse_reset();
        run_vec(16'b101011, 16'b000001, 6, 1'b0);

        // Reset mid-match discards progress.
        pulse_reset();
        run_vec(16'b101, 16'b000, 3, 1'b0);
        pulse_reset();
        run_vec(16'b1011, 16'b0001, 4, 1'b0);

        // Three-bit pattern 110.
        pulse_reset();
        run_vec(16'b1110, 16'b0001, 4, 1'b1);

        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("q_drained", 0, 1'(q1.size() == 0 && q2.size() == 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
